tetris_drop_ctrl: RTL and testbench

Vertical-motion controller for the falling piece. Consumes the single-cycle soft-drop pulses produced by the down-button conditioning stage and merges them with a level-dependent gravity timer. The merged result goes to the board logic as move-down requests under a req/ack handshake. When the piece rests on the stack, it runs the landing and lock sequence and issues a one-cycle lock request.

---
 rtl/tetris_drop_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_tetris_drop_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_drop_ctrl.sv
// tetris_drop_ctrl
//
// Vertical-motion controller for the falling piece. Merges a level-dependent
// gravity timer with single-cycle soft-drop pulses into move-down requests
// for the board (req/ack handshake). When the piece rests on the stack it
// runs the landing/lock sequence and issues a one-cycle lock request.
//
// Build option:
//   DROP_LOCK_DELAY_EN - when defined, a blocked trigger enters a LAND state
//                        that waits LOCK_CYCLES before locking (and can fall
//                        again if the floor disappears). When undefined, a
//                        blocked trigger locks immediately and LOCK_CYCLES is
//                        unused.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   spawn_valid  one-cycle pulse: new piece placed (honoured only in IDLE)
//   level        game level, sampled on an accepted spawn
//   soft_drop    one-cycle pulse from the down-button stage
//   down_blocked piece cannot move down from its current position
//   pause        freezes counters and transitions (except REQ->FALL on ack)
//   move_ack     board accepted and applied a move-down
//   move_req     move-down request, held until acknowledged
//   lock_req     one-cycle pulse: lock the piece into the board
//   falling      high whenever the controller is not IDLE

module tetris_drop_ctrl #(
  parameter logic [24:0] GRAV_BASE   = 25'd25_000_000,
  parameter logic [24:0] GRAV_STEP   = 25'd2_000_000,
  parameter logic [24:0] GRAV_MIN    = 25'd2_000_000,
  parameter logic [24:0] LOCK_CYCLES = 25'd12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spawn_valid,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       down_blocked,
  input  logic       pause,
  input  logic       move_ack,
  output logic       move_req,
  output logic       lock_req,
  output logic       falling
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFall = 3'd1,
    StReq  = 3'd2,
`ifdef DROP_LOCK_DELAY_EN
    StLand = 3'd3,
`endif
    StLock = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [24:0] grav_cnt_q, grav_cnt_d;
  logic [24:0] period_q, period_d;
  logic [24:0] period_new;
  logic [28:0] grav_prod;
  logic        grav_trig;
  logic        move_req_q, lock_req_q, falling_q;

`ifdef DROP_LOCK_DELAY_EN
  logic [24:0] lock_cnt_q, lock_cnt_d;
`else
  logic        unused_lock_cycles;
  assign unused_lock_cycles = ^LOCK_CYCLES;
`endif

  // Full-width product so high levels saturate instead of wrapping.
  assign grav_prod = {25'd0, level} * {4'd0, GRAV_STEP};

  always_comb begin
    if (grav_prod >= {4'd0, GRAV_BASE - GRAV_MIN}) begin
      period_new = GRAV_MIN;
    end else begin
      period_new = GRAV_BASE - grav_prod[24:0];
    end
  end

  // Gravity expiry and soft drop collapse into a single trigger.
  assign grav_trig = (grav_cnt_q == period_q - 25'd1) || soft_drop;

  always_comb begin
    state_d    = state_q;
    grav_cnt_d = grav_cnt_q;
    period_d   = period_q;
`ifdef DROP_LOCK_DELAY_EN
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (spawn_valid && !pause) begin
          period_d   = period_new;
          grav_cnt_d = '0;
          state_d    = StFall;
        end
      end
      StFall: begin
        if (!pause) begin
          if (grav_trig) begin
            grav_cnt_d = '0;
            if (down_blocked) begin
`ifdef DROP_LOCK_DELAY_EN
              lock_cnt_d = '0;
              state_d    = StLand;
`else
              state_d    = StLock;
`endif
            end else begin
              state_d = StReq;
            end
          end else begin
            grav_cnt_d = grav_cnt_q + 25'd1;
          end
        end
      end
      StReq: begin
        // Ack is honoured even while paused; soft_drop is dropped here.
        grav_cnt_d = '0;
        if (move_ack) begin
          state_d = StFall;
        end
      end
`ifdef DROP_LOCK_DELAY_EN
      StLand: begin
        if (!pause) begin
          // Losing the floor beats a simultaneous soft drop.
          if (!down_blocked) begin
            grav_cnt_d = '0;
            state_d    = StFall;
          end else if ((lock_cnt_q == LOCK_CYCLES - 25'd1) || soft_drop) begin
            state_d = StLock;
          end else begin
            lock_cnt_d = lock_cnt_q + 25'd1;
          end
        end
      end
`endif
      StLock: begin
        if (!pause) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      grav_cnt_q <= '0;
      period_q   <= '0;
`ifdef DROP_LOCK_DELAY_EN
      lock_cnt_q <= '0;
`endif
      move_req_q <= 1'b0;
      lock_req_q <= 1'b0;
      falling_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grav_cnt_q <= grav_cnt_d;
      period_q   <= period_d;
`ifdef DROP_LOCK_DELAY_EN
      lock_cnt_q <= lock_cnt_d;
`endif
      move_req_q <= (state_d == StReq);
      // Pulse on entry only, so a pause held in LOCK cannot stretch it.
      lock_req_q <= (state_d == StLock) && (state_q != StLock);
      falling_q  <= (state_d != StIdle);
    end
  end

  assign move_req = move_req_q;
  assign lock_req = lock_req_q;
  assign falling  = falling_q;

endmodule

// File: tb/tb_tetris_drop_ctrl.sv
// Bench for tetris_drop_ctrl with GRAV_BASE=20, GRAV_STEP=4, GRAV_MIN=4,
// LOCK_CYCLES=6. Directed sequences plus random stimulus; a countdown-based
// reference model is checked on every clock edge.

module tb_tetris_drop_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       spawn_valid, soft_drop, down_blocked, pause, move_ack;
  logic [3:0] level;
  logic       move_req, lock_req, falling;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DROP_LOCK_DELAY_EN
  localparam bit LandEn = 1'b1;
`else
  localparam bit LandEn = 1'b0;
`endif
  localparam int LockN = 6;

  tetris_drop_ctrl #(
    .GRAV_BASE  (25'd20),
    .GRAV_STEP  (25'd4),
    .GRAV_MIN   (25'd4),
    .LOCK_CYCLES(25'd6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spawn_valid (spawn_valid),
    .level       (level),
    .soft_drop   (soft_drop),
    .down_blocked(down_blocked),
    .pause       (pause),
    .move_ack    (move_ack),
    .move_req    (move_req),
    .lock_req    (lock_req),
    .falling     (falling)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  localparam int PhIdle = 0, PhFall = 1, PhReq = 2, PhLand = 3, PhLock = 4;
  int m_phase = PhIdle;
  int m_left, m_lock_left, m_period;
  bit m_pulse = 1'b0;

  function automatic int period_of(input int lvl);
    int p;
    p = 20 - 4 * lvl;
    if (p < 4) p = 4;
    return p;
  endfunction

  task automatic model_step();
    m_pulse = 1'b0;
    case (m_phase)
      PhIdle: if (spawn_valid && !pause) begin
        m_period = period_of(int'(level));
        m_left   = m_period;
        m_phase  = PhFall;
      end
      PhFall: if (!pause) begin
        if (m_left == 1 || soft_drop) begin
          if (!down_blocked) m_phase = PhReq;
          else if (LandEn) begin
            m_phase = PhLand;
            m_lock_left = LockN;
          end else begin
            m_phase = PhLock;
            m_pulse = 1'b1;
          end
        end else m_left--;
      end
      PhReq: if (move_ack) begin
        m_phase = PhFall;
        m_left  = m_period;
      end
      PhLand: if (!pause) begin
        if (!down_blocked) begin
          m_phase = PhFall;
          m_left  = m_period;
        end else if (m_lock_left == 1 || soft_drop) begin
          m_phase = PhLock;
          m_pulse = 1'b1;
        end else m_lock_left--;
      end
      PhLock: if (!pause) m_phase = PhIdle;
      default: m_phase = PhIdle;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = PhIdle;
        m_pulse = 1'b0;
      end else begin
        model_step();
      end
      #1;
      check("model_move_req", 32'(move_req), 32'(m_phase == PhReq));
      check("model_lock_req", 32'(lock_req), 32'(m_pulse));
      check("model_falling", 32'(falling), 32'(m_phase != PhIdle));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    spawn_valid = 1'b0; soft_drop = 1'b0; down_blocked = 1'b0;
    pause = 1'b0; move_ack = 1'b0; level = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Counts edges from the one sampling spawn (=1) until move_req is seen high.
  task automatic spawn_and_wait(input logic [3:0] lvl, output int first);
    first = -1;
    level = lvl;
    spawn_valid = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      spawn_valid = 1'b0;
      if (move_req) begin
        first = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] lvl;
    int         first;
    int         gap;
  } lvl_vec_t;

  lvl_vec_t vecs[7];

  initial begin
    int first, gap, hi, cnt, lock_at;
    bit seen_req, seen_lock;

    vecs[0] = '{4'd0, 21, 21};
    vecs[1] = '{4'd1, 17, 17};
    vecs[2] = '{4'd2, 13, 13};
    vecs[3] = '{4'd3, 9, 9};
    vecs[4] = '{4'd4, 5, 5};
    vecs[5] = '{4'd7, 5, 5};
    vecs[6] = '{4'd15, 5, 5};

    do_reset();
    check("reset_move_req", 32'(move_req), 32'd0);
    check("reset_lock_req", 32'(lock_req), 32'd0);
    check("reset_falling", 32'(falling), 32'd0);

    // Gravity period per level, immediate ack.
    foreach (vecs[v]) begin
      do_reset();
      spawn_and_wait(vecs[v].lvl, first);
      check($sformatf("grav_first_l%0d", vecs[v].lvl), first, vecs[v].first);
      move_ack = 1'b1;
      tick();
      move_ack = 1'b0;
      check("ack_drop", 32'(move_req), 32'd0);
      gap = -1;
      for (int i = 2; i <= 200; i++) begin
        tick();
        if (move_req) begin
          gap = i;
          break;
        end
      end
      check($sformatf("grav_gap_l%0d", vecs[v].lvl), gap, vecs[v].gap);
    end

    // Soft drop at FALL cycle 3, ack withheld, second soft drop during REQ.
    do_reset();
    level = 4'd0;
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    tick();
    tick();
    soft_drop = 1'b1;
    tick();
    soft_drop = 1'b0;
    check("sd_rise", 32'(move_req), 32'd1);
    hi = 1;
    for (int k = 1; k <= 9; k++) begin
      soft_drop = (k == 3);
      tick();
      soft_drop = 1'b0;
      if (move_req) hi++;
    end
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    check("sd_ack_drop", 32'(move_req), 32'd0);
    check("sd_req_len", hi, 10);
    cnt = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (move_req) begin
        cnt = i;
        break;
      end
    end
    check("sd_regrav", cnt, 20);

    // Landing and lock, level 7 (period 4).
    do_reset();
    level = 4'd7;
    down_blocked = 1'b1;
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    seen_req = 1'b0;
    lock_at = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (move_req) seen_req = 1'b1;
      if (lock_req) begin
        lock_at = i;
        break;
      end
    end
    check("land_lock_at", lock_at, LandEn ? 10 : 4);
    check("land_no_req", 32'(seen_req), 32'd0);
    check("land_falling_hi", 32'(falling), 32'd1);
    tick();
    check("land_lock_len", 32'(lock_req), 32'd0);
    check("land_falling_lo", 32'(falling), 32'd0);

`ifdef DROP_LOCK_DELAY_EN
    // Floor vanishes in LAND cycle 3: back to FALL, no lock.
    do_reset();
    level = 4'd7;
    down_blocked = 1'b1;
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    seen_lock = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (lock_req) seen_lock = 1'b1;
    end
    down_blocked = 1'b0;
    tick();
    check("unland_falling", 32'(falling), 32'd1);
    cnt = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (lock_req) seen_lock = 1'b1;
      if (move_req) begin
        cnt = i;
        break;
      end
    end
    check("unland_no_lock", 32'(seen_lock), 32'd0);
    check("unland_req_at", cnt, 4);
`endif

    // Asynchronous reset while move_req is high.
    do_reset();
    spawn_and_wait(4'd7, first);
    check("rst_pre_req", 32'(move_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_move_req", 32'(move_req), 32'd0);
    check("rst_async_falling", 32'(falling), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Pause held 50 cycles in FALL delays the request by exactly 50.
    do_reset();
    level = 4'd0;
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    cnt = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt++;
    end
    pause = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      cnt++;
    end
    pause = 1'b0;
    first = -1;
    for (int i = 0; i < 200; i++) begin
      if (move_req) begin
        first = cnt;
        break;
      end
      tick();
      cnt++;
    end
    check("pause_delay", first, 71);
    // Paused in REQ: request holds, ack still completes it.
    pause = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("pause_req_hold", 32'(move_req), 32'd1);
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    check("pause_ack", 32'(move_req), 32'd0);
    pause = 1'b0;

    // Random stimulus against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset = 1'b0;
      spawn_valid = ($urandom_range(0, 5) == 0);
      level = 4'($urandom_range(0, 15));
      soft_drop = ($urandom_range(0, 9) == 0);
      pause = ($urandom_range(0, 11) == 0);
      move_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) down_blocked = ~down_blocked;
      tick();
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b1;
      end
    end
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
